// File: rtl/ks_adder_pipe_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: width/latency math and limits.
package ks_pkg;

  localparam int KS_MAX_WIDTH = 64;

  // Ceiling log2 for elaboration-time sizing; bounded loop so it stays a constant function.
  function automatic int ks_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Cycles from an accepted beat to out_valid: one preprocessing register plus one
  // register per group of prefix levels (the last group's register is the output register).
  function automatic int ks_latency(input int width, input int lps);
    int l;
    l = ks_clog2(width);
    return (l + lps - 1) / lps + 1;
  endfunction

endpackage

// File: rtl/ks_adder_pipe_prefix_level.sv
// One Kogge-Stone prefix level: merges each (P,G) pair with the pair DIST bits below it.
module ks_prefix_level #(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] g_in,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] g_out
);

  // Bits below DIST have no partner at this span and pass through unchanged.
  always_comb begin
    p_out = p_in;
    g_out = g_in;
    for (int i = DIST; i < WIDTH; i++) begin
      g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
      p_out[i] = p_in[i] & p_in[i-DIST];
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a global-stall valid/ready stream.
// Optional build macro: KS_ADDER_PIPE_SAT_EN saturates s on signed overflow.
//
// Handshake: a beat moves on every edge where adv = ~out_valid | out_ready.
// in_ready equals adv, so an input beat is taken when in_valid & in_ready; all
// stages shift together and bubbles stay in place. When adv is low every stage
// and the output registers hold, so s/cout/ovf are stable while out_valid waits.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int LVL_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int L    = ks_clog2(WIDTH);
  localparam int NSTG = ks_latency(WIDTH, LVL_PER_STAGE) - 1;
  localparam int MSB  = WIDTH - 1;

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic [WIDTH-1:0] b_eff, p_pre, g_pre;
  logic             c0;

  // Operand preprocessing; the carry-in is folded into G[0] so the prefix tree needs no extra input.
  always_comb begin
    b_eff    = sub ? ~b : b;
    c0       = sub | cin;
    p_pre    = a ^ b_eff;
    g_pre    = a & b_eff;
    g_pre[0] = (a[0] & b_eff[0]) | ((a[0] | b_eff[0]) & c0);
  end

  // Stage registers 0..NSTG-1: index 0 holds preprocessed operands, later ones hold partial prefixes.
  logic [WIDTH-1:0] st_p  [NSTG];
  logic [WIDTH-1:0] st_g  [NSTG];
  logic [WIDTH-1:0] st_p0 [NSTG];
  logic             st_c0 [NSTG];
  logic             st_am [NSTG];
  logic             st_bm [NSTG];
  logic [NSTG-1:0]  st_v;

  logic [WIDTH-1:0] lvl_pin  [L];
  logic [WIDTH-1:0] lvl_gin  [L];
  logic [WIDTH-1:0] lvl_pout [L];
  logic [WIDTH-1:0] lvl_gout [L];

  // A level whose index is a multiple of LVL_PER_STAGE starts a new stage and reads a register.
  for (genvar k = 0; k < L; k++) begin : g_lvl
    if (k % LVL_PER_STAGE == 0) begin : g_from_reg
      assign lvl_pin[k] = st_p[k / LVL_PER_STAGE];
      assign lvl_gin[k] = st_g[k / LVL_PER_STAGE];
    end else begin : g_from_lvl
      assign lvl_pin[k] = lvl_pout[k-1];
      assign lvl_gin[k] = lvl_gout[k-1];
    end
    ks_prefix_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_lvl (
      .p_in  (lvl_pin[k]),
      .g_in  (lvl_gin[k]),
      .p_out (lvl_pout[k]),
      .g_out (lvl_gout[k])
    );
  end

  // Datapath stage registers; not reset because the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      st_p[0]  <= p_pre;
      st_g[0]  <= g_pre;
      st_p0[0] <= p_pre;
      st_c0[0] <= c0;
      st_am[0] <= a[MSB];
      st_bm[0] <= b_eff[MSB];
      for (int j = 1; j < NSTG; j++) begin
        st_p[j]  <= lvl_pout[j*LVL_PER_STAGE-1];
        st_g[j]  <= lvl_gout[j*LVL_PER_STAGE-1];
        st_p0[j] <= st_p0[j-1];
        st_c0[j] <= st_c0[j-1];
        st_am[j] <= st_am[j-1];
        st_bm[j] <= st_bm[j-1];
      end
    end
  end

  logic [WIDTH-1:0] g_fin, carry, s_raw, s_nxt;
  logic             cout_nxt, ovf_nxt;
  assign g_fin = lvl_gout[L-1];

  // Final stage: sum bits from the saved propagate vector and the group generates one bit below.
  always_comb begin
    carry    = {g_fin[WIDTH-2:0], st_c0[NSTG-1]};
    s_raw    = st_p0[NSTG-1] ^ carry;
    cout_nxt = g_fin[MSB];
    ovf_nxt  = (st_am[NSTG-1] == st_bm[NSTG-1]) && (s_raw[MSB] != st_am[NSTG-1]);
    s_nxt    = s_raw;
`ifdef KS_ADDER_PIPE_SAT_EN
    if (ovf_nxt) s_nxt = st_am[NSTG-1] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
`endif
  end

  // Valid chain and output registers; reset drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_v      <= '0;
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      st_v[0] <= in_valid;
      for (int j = 1; j < NSTG; j++) st_v[j] <= st_v[j-1];
      out_valid <= st_v[NSTG-1];
      if (st_v[NSTG-1]) begin
        s    <= s_nxt;
        cout <= cout_nxt;
        ovf  <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: directed 8-bit vectors plus a 32-bit sweep over three stage depths.
module tb_ks_adder_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- 8-bit DUT ----------------
  logic       in_valid, in_ready, out_valid, out_ready, cin, sub, cout, ovf;
  logic [7:0] a, b, s;

  ks_adder_pipe #(.WIDTH(8), .LVL_PER_STAGE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  typedef struct packed {
    logic [7:0] va, vb;
    logic       vcin, vsub;
    logic [7:0] s_wrap, s_sat;
    logic       vcout, vovf;
  } vec_t;
  vec_t vt [12];

  logic [9:0] exp_q[$];   // {ovf, cout, s}

  // ---------------- 32-bit DUTs (LVL_PER_STAGE 1, 2, 5) ----------------
  logic [2:0]  iv32, ir32, ov32, or32, co32, of32;
  logic [31:0] a32, b32;
  logic        cin32, sub32;
  logic [31:0] s32 [3];
  logic [33:0] exp32_q [3][$];
  logic        stall_en;

  function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb);
    logic signed [33:0] sx, sy, sr;
    logic [32:0] us;
    logic co, ov;
    logic [31:0] r;
    sx = {{2{x[31]}}, x};
    sy = {{2{y[31]}}, y};
    if (sb) begin
      sr = sx - sy;
      co = (x >= y);
    end else begin
      sr = sx + sy + {33'b0, ci};
      us = {1'b0, x} + {1'b0, y} + {32'b0, ci};
      co = us[32];
    end
    ov = (sr > 34'sd2147483647) || (sr < -34'sd2147483648);
    r  = sr[31:0];
`ifdef KS_ADDER_PIPE_SAT_EN
    if (ov) r = x[31] ? 32'h8000_0000 : 32'h7fff_ffff;
`endif
    return {ov, co, r};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g32
    localparam int LPS = (g == 0) ? 1 : (g == 1) ? 2 : 5;
    ks_adder_pipe #(.WIDTH(32), .LVL_PER_STAGE(LPS)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32[g]), .in_ready(ir32[g]),
      .a(a32), .b(b32), .cin(cin32), .sub(sub32),
      .out_valid(ov32[g]), .out_ready(or32[g]),
      .s(s32[g]), .cout(co32[g]), .ovf(of32[g])
    );

    // Scoreboard monitor: pop on each completed output handshake.
    always @(negedge clk) begin
      logic [33:0] e;
      #2;
      if (!rst && ov32[g] && or32[g]) begin
        if (exp32_q[g].size() == 0) begin
          check($sformatf("w32_lps%0d unexpected beat", LPS), 64'(ov32[g]), 64'd0);
        end else begin
          e = exp32_q[g].pop_front();
          check($sformatf("w32_lps%0d result", LPS), 64'({of32[g], co32[g], s32[g]}), 64'(e));
        end
      end
    end
  end

  // Random downstream stalls for the 32-bit sweep.
  always @(negedge clk) begin
    if (stall_en) begin
      for (int g = 0; g < 3; g++) or32[g] = ($urandom_range(0, 3) != 0);
    end else begin
      or32 = 3'b111;
    end
  end

  // ---------------- 8-bit scoreboard monitor ----------------
  logic       held_v;
  logic [9:0] held;
  always @(negedge clk) begin
    logic [9:0] e;
    #2;
    if (rst) begin
      held_v = 1'b0;
    end else if (out_valid) begin
      if (held_v) check("w8 stall hold", 64'({ovf, cout, s}), 64'(held));
      if (out_ready) begin
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          check("w8 unexpected beat", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("w8 result", 64'({ovf, cout, s}), 64'(e));
        end
      end else begin
        held_v = 1'b1;
        held   = {ovf, cout, s};
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send8(input int idx);
    int guard;
    logic [7:0] se;
    guard = 0;
    @(negedge clk);
    a = vt[idx].va; b = vt[idx].vb; cin = vt[idx].vcin; sub = vt[idx].vsub;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      check("w8 send timeout", 64'(in_ready), 64'd1);
    end else begin
`ifdef KS_ADDER_PIPE_SAT_EN
      se = vt[idx].s_sat;
`else
      se = vt[idx].s_wrap;
`endif
      exp_q.push_back({vt[idx].vovf, vt[idx].vcout, se});
      n_acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb);
    logic [2:0]  done;
    logic [33:0] e;
    int guard;
    done  = '0;
    guard = 0;
    e = model32(x, y, ci, sb);
    while (done != 3'b111 && guard < 200) begin
      @(negedge clk);
      a32 = x; b32 = y; cin32 = ci; sub32 = sb;
      iv32 = ~done;
      #1;
      for (int g = 0; g < 3; g++) begin
        if (!done[g] && ir32[g]) begin
          exp32_q[g].push_back(e);
          done[g] = 1'b1;
        end
      end
      guard++;
    end
    if (done != 3'b111) check("w32 send timeout", 64'(done), 64'h7);
    @(posedge clk);
    #1;
    iv32 = '0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() + exp32_q[0].size() + exp32_q[1].size() + exp32_q[2].size()) != 0
           && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int lat32 [3];
    logic [2:0] seen;
    logic stale;

    vt[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
    vt[2]  = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0};
    vt[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
    vt[4]  = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 8'h47, 1'b0, 1'b0};
    vt[5]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
    vt[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[7]  = '{8'h3C, 8'hC3, 1'b0, 1'b1, 8'h79, 8'h79, 1'b0, 1'b0};
    vt[8]  = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[9]  = '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
    vt[10] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1};
    vt[11] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'hFE, 8'hFE, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    iv32 = '0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; stall_en = 1'b0;
    held_v = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset s", 64'(s), 64'd0);
    check("reset cout_ovf", 64'({cout, ovf}), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);

    // Latency of one beat through an empty 8-bit pipe
    send8(0);
    lat = 1;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 20) break;
      lat++;
    end
    check("w8 latency", 64'(lat), 64'd4);

    // Back-to-back stream, no stalls
    for (int i = 1; i < 12; i++) send8(i);
    drain(50);

    // Backpressure: 6 beats with the sink stalled
    @(negedge clk);
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send8(i);
      end
      begin
        repeat (10) @(posedge clk);
        #2;
        check("bp beats held", 64'(n_acc), 64'd4);
        check("bp in_ready low", 64'(in_ready), 64'd0);
        check("bp out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
      end
    join
    drain(50);
    check("bp no loss", 64'(exp_q.size()), 64'd0);

    // Reset with three beats in flight: none of them may surface
    send8(4);
    drain(20);
    send8(6); send8(7); send8(8);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst s", 64'(s), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("midrst no stale beat", 64'(stale), 64'd0);
    send8(3);
    drain(20);
    check("w8 queue empty", 64'(exp_q.size()), 64'd0);

    // 32-bit latency for LVL_PER_STAGE 1, 2, 5
    send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    seen = '0;
    lat32[0] = 0; lat32[1] = 0; lat32[2] = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!seen[g] && ov32[g]) begin
          seen[g]  = 1'b1;
          lat32[g] = c;
        end
      end
    end
    check("w32 latency lps1", 64'(lat32[0]), 64'd6);
    check("w32 latency lps2", 64'(lat32[1]), 64'd4);
    check("w32 latency lps5", 64'(lat32[2]), 64'd2);

    // 32-bit corners and a random sweep under random stalls
    stall_en = 1'b1;
    send32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    send32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send32(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
    send32(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    send32(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    stall_en = 1'b0;
    drain(300);
    check("w32 lps1 no loss", 64'(exp32_q[0].size()), 64'd0);
    check("w32 lps2 no loss", 64'(exp32_q[1].size()), 64'd0);
    check("w32 lps5 no loss", 64'(exp32_q[2].size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
